wb_trace_buffer: RTL and testbench
==================================

// Module: wb_trace_buffer
//
// PURPOSE
// Observer for the mips_core register-file writeback port. Each committed
// write (pc, rd, data) is captured into an internal FIFO, and a ready/valid
// reader drains the FIFO at its own pace, for example the bench or a debug
// UART. It is the reading end of the core's writeback stream. Loss is
// reported through a sticky overflow flag and a drop counter.
//
// PARAMETERS
// DATA_W  32  writeback data width
// REG_W    5  register index width (32 GPRs)
// PC_W    32  program counter width
// DEPTH   16  FIFO entries; must be a power of 2, >= 2
// CNT_W    5  occupancy width; equals log2(DEPTH)+1
//
// PORTS
// clock        in   1       sole clock; all state changes on posedge
// reset_n      in   1       synchronous, active-low reset
// wb_en        in   1       core writes register file this cycle
// wb_rd        in   REG_W   destination register index
// wb_data      in   DATA_W  value written
// wb_pc        in   PC_W    PC of the committing instruction
// trace_valid  out  1       head entry available
// trace_ready  in   1       reader accepts head entry
// trace_rd     out  REG_W   head entry register index
// trace_data   out  DATA_W  head entry data
// trace_pc     out  PC_W    head entry PC
// count        out  CNT_W   current occupancy, 0..DEPTH
// overflow     out  1       sticky: at least one capture was dropped
// drop_cnt     out  16      dropped captures, saturates at 16'hFFFF
// clear_ovf    in   1       clears overflow and drop_cnt
//
// BEHAVIOUR
// - Reset (reset_n==0 at posedge): wr_ptr, rd_ptr, count, overflow and
//   drop_cnt go to 0. trace_valid is 0. Storage contents are don't-care.
//   Reset mid-stream discards all entries. No push and no pop occur in the
//   reset cycle.
// - Push request: push_req = wb_en && (wb_rd != 0). Writes to $zero are
//   never captured.
// - Pop: pop = trace_valid && trace_ready.
// - FIFO is first-word-fall-through:
//   - trace_valid = (count != 0).
//   - trace_rd, trace_data and trace_pc are driven combinationally from
//     mem[rd_ptr]. They must hold stable while valid && !ready.
// - Latency: an entry pushed at posedge N shows on the trace_* outputs
//   after posedge N. There is no same-cycle bypass. When the FIFO is empty,
//   a push and ready in one cycle produce no pop that cycle.
// - Push accepted when count < DEPTH, or when count == DEPTH and pop is
//   also true in that cycle (full + simultaneous pop + push accepted).
// - Both pointers wrap modulo DEPTH. count rises by 1 on push-only, falls
//   by 1 on pop-only, and is unchanged on push+pop.
// - Drop happens when push_req is true, the FIFO is full and there is no
//   pop. On a drop:
//   - overflow is set to 1.
//   - drop_cnt increments, saturating at 16'hFFFF.
//   - FIFO contents are unchanged (newest entry lost, oldest kept).
// - clear_ovf sets overflow to 0 and drop_cnt to 0 on the next posedge.
//   If a drop happens in the same cycle, the drop wins: overflow becomes 1
//   and drop_cnt becomes 1.
// - Pop on an empty FIFO is impossible, because trace_valid is 0.
//   trace_ready is ignored while empty.
// - Entries leave in strict order of capture.
//
// TESTING
// 1. Reset and filtering. Hold reset_n=0 for 2 cycles, then wb_en=1,
//    wb_rd=0, data=32'hDEAD -> count stays 0, trace_valid=0, overflow=0.
// 2. Single capture. Push pc=32'h0040_0000, rd=8, data=32'h1234 at cycle N
//    -> trace_valid=1 after cycle N, with trace_rd=8 and trace_data=32'h1234.
//    Then trace_ready=1 for one cycle -> count=0.
// 3. Fill and overflow. Push 18 entries with data 1..18 and ready=0
//    -> count=16, overflow=1, drop_cnt=2. Draining then yields data 1..16
//    in order.
// 4. Full with simultaneous push and pop. At count=16, push data=99 with
//    ready=1 -> count stays 16, overflow stays 0, and 99 is the last entry
//    drained.
// 5. Clear versus drop. When full, clear_ovf=1 in the same cycle as a drop
//    -> overflow=1, drop_cnt=1. Next cycle clear_ovf=1 with no push
//    -> overflow=0, drop_cnt=0.
// 6. Reset mid-operation. With count=5, pulse reset_n=0 for one cycle
//    -> count=0, trace_valid=0, drop_cnt=0. A new push then drains
//    correctly, and pointer wrap is checked over 40 push/pop pairs.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// Capture buffer for the register-file writeback port: committed writes are
// queued in a first-word-fall-through FIFO and drained by a ready/valid reader.
module wb_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wb_en,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [PC_W-1:0]   wb_pc,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [REG_W-1:0]  trace_rd,
    output logic [DATA_W-1:0] trace_data,
    output logic [PC_W-1:0]   trace_pc,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic [15:0]       drop_cnt,
    input  logic              clear_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [15:0]      DROP_MAX = 16'hFFFF;

    logic [REG_W-1:0]  mem_rd   [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PC_W-1:0]   mem_pc   [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_req;
    logic          pop;
    logic          full;
    logic          push;
    logic          drop;

    // Writes to $zero have no architectural effect and are never traced.
    assign push_req    = wb_en && (wb_rd != '0);
    assign trace_valid = (count != '0);
    assign pop         = trace_valid && trace_ready;
    assign full        = (count == CNT_FULL);
    assign push        = push_req && (!full || pop);
    assign drop        = push_req && full && !pop;

    assign trace_rd   = mem_rd[rd_ptr];
    assign trace_data = mem_data[rd_ptr];
    assign trace_pc   = mem_pc[rd_ptr];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (reset_n && push) begin
            mem_rd[wr_ptr]   <= wb_rd;
            mem_data[wr_ptr] <= wb_data;
            mem_pc[wr_ptr]   <= wb_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            // A drop in the same cycle as a clear wins: the clear wipes the
            // history, then this drop is counted as the first one.
            if (drop) begin
                overflow <= 1'b1;
                if (clear_ovf) begin
                    drop_cnt <= 16'd1;
                end else if (drop_cnt != DROP_MAX) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end else if (clear_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Randomized scoreboard bench for wb_trace_buffer: a queue-based model predicts
// captured entries and status; a negedge monitor checks the FIFO head and flags.
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;

    logic        clock;
    logic        reset_n;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic        trace_valid;
    logic        trace_ready;
    logic [4:0]  trace_rd;
    logic [31:0] trace_data;
    logic [31:0] trace_pc;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        clear_ovf;

    wb_trace_buffer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_pc       (wb_pc),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_rd    (trace_rd),
        .trace_data  (trace_data),
        .trace_pc    (trace_pc),
        .count       (count),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .clear_ovf   (clear_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    ent_t exp_q[$];
    int   m_cnt;
    int   m_drop;
    bit   m_ovf;
    bit   chk_en;
    int   n_vec;
    int   n_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model predicts the state after the edge.
    task automatic cyc(input logic en, input logic [4:0] rd, input logic [31:0] data,
                       input logic [31:0] pc, input logic rdy, input logic clr,
                       input logic rst);
        int  n_cnt;
        int  n_drop;
        bit  n_ovf;
        bit  pop;
        bit  preq;
        wb_en       = en;
        wb_rd       = rd;
        wb_data     = data;
        wb_pc       = pc;
        trace_ready = rst ? 1'b0 : rdy;
        clear_ovf   = clr;
        reset_n     = !rst;
        n_cnt  = m_cnt;
        n_drop = m_drop;
        n_ovf  = m_ovf;
        if (rst) begin
            n_cnt  = 0;
            n_drop = 0;
            n_ovf  = 0;
        end else begin
            pop  = (m_cnt != 0) && rdy;
            preq = en && (rd != 0);
            if (preq && (m_cnt < DEPTH || pop)) begin
                exp_q.push_back('{rd: rd, data: data, pc: pc});
                n_cnt++;
            end
            if (pop) n_cnt--;
            if (clr) begin
                n_ovf  = 0;
                n_drop = 0;
            end
            if (preq && m_cnt == DEPTH && !pop) begin
                n_ovf  = 1;
                n_drop = (n_drop < 65535) ? n_drop + 1 : 65535;
            end
        end
        @(posedge clock);
        #1;
        m_cnt  = n_cnt;
        m_drop = n_drop;
        m_ovf  = n_ovf;
        if (rst) exp_q.delete();
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data, input logic rdy);
        cyc(1'b1, rd, data, $urandom, rdy, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic rdy, input logic clr);
        cyc(1'b0, 5'd0, 32'd0, 32'd0, rdy, clr, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && m_cnt != 0; i++) idle(1'b1, 1'b0);
        chk("drain_empty", count, 0);
    endtask

    function automatic logic [4:0] nz_rd();
        return 5'($urandom_range(1, 31));
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            chk("count", count, m_cnt);
            chk("valid", trace_valid, m_cnt != 0);
            chk("overflow", overflow, m_ovf);
            chk("drop_cnt", drop_cnt, m_drop);
            if (trace_valid) begin
                if (exp_q.size() == 0) begin
                    chk("head_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("head_rd", trace_rd, exp_q[0].rd);
                    chk("head_data", trace_data, exp_q[0].data);
                    chk("head_pc", trace_pc, exp_q[0].pc);
                    if (trace_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        n_vec  = 0;
        n_err  = 0;
        chk_en = 0;
        m_cnt  = 0;
        m_drop = 0;
        m_ovf  = 0;

        // reset and $zero filtering
        cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk_en = 1;
        chk("rst_count", count, 0);
        chk("rst_valid", trace_valid, 0);
        cyc(1'b1, 5'd0, 32'hDEAD, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("zero_count", count, 0);
        chk("zero_valid", trace_valid, 0);
        chk("zero_ovf", overflow, 0);

        // single capture
        cyc(1'b1, 5'd8, 32'h1234, 32'h0040_0000, 1'b0, 1'b0, 1'b0);
        chk("single_valid", trace_valid, 1);
        chk("single_rd", trace_rd, 8);
        chk("single_data", trace_data, 32'h1234);
        chk("single_pc", trace_pc, 32'h0040_0000);
        idle(1'b1, 1'b0);
        chk("single_drained", count, 0);

        // push into empty with ready high: no pop that cycle
        cyc(1'b1, 5'd3, 32'h55, 32'h4, 1'b1, 1'b0, 1'b0);
        chk("nobypass_count", count, 1);
        drain();

        // fill and overflow
        for (int i = 1; i <= 18; i++) push(nz_rd(), 32'(i), 1'b0);
        chk("fill_count", count, 16);
        chk("fill_ovf", overflow, 1);
        chk("fill_drop", drop_cnt, 2);
        drain();

        // full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) push(nz_rd(), 32'(101 + i), 1'b0);
        idle(1'b0, 1'b1);
        chk("clr_ovf", overflow, 0);
        push(5'd9, 32'd99, 1'b1);
        chk("fullpp_count", count, 16);
        chk("fullpp_ovf", overflow, 0);

        // clear versus drop
        cyc(1'b1, 5'd4, 32'd77, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("clrdrop_ovf", overflow, 1);
        chk("clrdrop_cnt", drop_cnt, 1);
        idle(1'b0, 1'b1);
        chk("clr2_ovf", overflow, 0);
        chk("clr2_cnt", drop_cnt, 0);
        drain();

        // reset mid-operation, then wrap
        for (int i = 0; i < 5; i++) push(nz_rd(), $urandom, 1'b0);
        chk("mid_count5", count, 5);
        cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("midrst_count", count, 0);
        chk("midrst_valid", trace_valid, 0);
        chk("midrst_drop", drop_cnt, 0);
        push(5'd12, 32'hCAFE, 1'b0);
        drain();
        for (int i = 0; i < 40; i++) push(nz_rd(), $urandom, 1'b1);
        drain();

        // randomized phases with varying reader speed
        for (int ph = 0; ph < 8; ph++) begin
            int thr;
            thr = (ph % 4) * 30;
            for (int i = 0; i < 300; i++) begin
                logic [4:0] rd;
                rd = ($urandom_range(0, 7) == 0) ? 5'd0 : nz_rd();
                cyc(1'($urandom_range(0, 3) != 0), rd, $urandom, $urandom,
                    1'($urandom_range(0, 99) < thr),
                    1'($urandom_range(0, 39) == 0),
                    1'($urandom_range(0, 499) == 0));
            end
        end
        drain();
        chk("final_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
